usart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single USART transmit path among up to four byte-stream requesters. It sits between client blocks and the `usart` TX FIFO write port, driving `tx_data_in`/`tx_write_en` and honouring `tx_full`. Each grant is a bounded burst, ended by the requester's last flag or by reaching the burst limit, so no client can monopolise the serial line.

---
 rtl/usart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_usart_tx_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter sharing one USART TX FIFO write port among NUM_REQ byte streams.
// Define USART_ARB_HEADER_EN to prefix each burst with a {4'hA, 2'b00, gid} header byte.
module usart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [7:0]           tx_data_out,
    output logic                 tx_write_en,
    input  logic                 tx_full
);

    localparam int unsigned IDX_W   = 2;
    localparam int unsigned SCAN_W  = IDX_W + 1;
    localparam int unsigned PAD_REQ = 4;
    localparam int unsigned DATA_W  = 8 * PAD_REQ;
    localparam int unsigned BEAT_W  = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     gid;
    logic [IDX_W-1:0]     gid_next;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_next;
    logic [BEAT_W-1:0]    beat;
    logic [BEAT_W-1:0]    beat_next;
    logic [NUM_REQ-1:0]   grant_next;
    logic                 busy_next;
    logic                 burst_end;

    logic [PAD_REQ-1:0]   valid_pad;
    logic [PAD_REQ-1:0]   last_pad;
    logic [PAD_REQ-1:0]   ready_pad;
    logic [PAD_REQ-1:0]   pick_oh;
    logic [DATA_W-1:0]    data_pad;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [SCAN_W-1:0]    scan;

    // Widen requester buses to four lanes so a 2-bit gid always indexes exactly.
    assign valid_pad = PAD_REQ'(req_valid);
    assign last_pad  = PAD_REQ'(req_last);
    assign data_pad  = DATA_W'(req_data);
    assign req_ready = ready_pad[NUM_REQ-1:0];

    // First valid requester at or after ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            scan = {1'b0, ptr} + SCAN_W'(k);
            if (scan >= SCAN_W'(NUM_REQ)) begin
                scan = scan - SCAN_W'(NUM_REQ);
            end
            if (!pick_found && valid_pad[scan[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IDX_W-1:0];
            end
        end
        pick_oh = PAD_REQ'(1) << pick_idx;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gid   <= '0;
            ptr   <= '0;
            beat  <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            gid   <= gid_next;
            ptr   <= ptr_next;
            beat  <= beat_next;
            grant <= grant_next;
            busy  <= busy_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        gid_next   = gid;
        ptr_next   = ptr;
        beat_next  = beat;
        grant_next = grant;
        burst_end  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_oh[NUM_REQ-1:0];
                    gid_next   = pick_idx;
                    beat_next  = '0;
`ifdef USART_ARB_HEADER_EN
                    state_next = HEADER;
`else
                    state_next = DATA;
`endif
                end
            end
`ifdef USART_ARB_HEADER_EN
            HEADER: begin
                if (tx_write_en) begin
                    state_next = DATA;
                end
            end
`endif
            DATA: begin
                if (tx_write_en) begin
                    beat_next = beat + BEAT_W'(1);
                    burst_end = last_pad[gid] || (beat == BEAT_W'(MAX_BURST - 1));
                    if (burst_end) begin
                        state_next = IDLE;
                        grant_next = '0;
                        ptr_next   = (gid == IDX_W'(NUM_REQ - 1)) ? '0 : gid + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    // Output logic: TX write path is combinational from state and live inputs
    always_comb begin
        tx_write_en = 1'b0;
        tx_data_out = 8'h00;
        ready_pad   = '0;
        case (state)
`ifdef USART_ARB_HEADER_EN
            HEADER: begin
                tx_data_out = {4'hA, 2'b00, gid};
                tx_write_en = !tx_full;
            end
`endif
            DATA: begin
                tx_data_out    = data_pad[{gid, 3'b000} +: 8];
                ready_pad[gid] = !tx_full;
                tx_write_en    = valid_pad[gid] && !tx_full;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Directed bench for usart_tx_arbiter (NUM_REQ=4, MAX_BURST=4); follows USART_ARB_HEADER_EN.
module tb_usart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  tx_data_out;
    logic        tx_write_en;
    logic        tx_full;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rr_byte [4] = '{8'h01, 8'h12, 8'h23, 8'h34};
    logic [31:0] rr_data;
    logic [1:0]  g;
    logic [3:0]  oh;

    usart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .busy        (busy),
        .tx_data_out (tx_data_out),
        .tx_write_en (tx_write_en),
        .tx_full     (tx_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_slot(input string tag, input logic [3:0] eg, input logic eb,
                               input logic ewe, input logic [3:0] erdy,
                               input logic chk_data, input logic [7:0] ed);
        check({tag, " grant"}, 32'(grant), 32'(eg));
        check({tag, " busy"}, 32'(busy), 32'(eb));
        check({tag, " write_en"}, 32'(tx_write_en), 32'(ewe));
        check({tag, " ready"}, 32'(req_ready), 32'(erdy));
        if (chk_data) check({tag, " data"}, 32'(tx_data_out), 32'(ed));
    endtask

    // Apply one cycle of inputs mid-cycle and let combinational outputs settle.
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f,
                         input logic [31:0] d);
        @(negedge clk);
        req_valid = v;
        req_last  = l;
        tx_full   = f;
        req_data  = d;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0;
        req_last  = 4'b0;
        req_data  = 32'h0;
        tx_full   = 1'b0;
        rr_data   = {rr_byte[3], rr_byte[2], rr_byte[1], rr_byte[0]};
        repeat (2) @(negedge clk);
        #1;
        expect_slot("reset", 4'b0, 1'b0, 1'b0, 4'b0, 1'b1, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Single requester 2: bytes 11, 22 with last on the second
        drive(4'b0100, 4'b0, 1'b0, 32'h0011_0000);
        expect_slot("single idle", 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 8'h00);
`ifdef USART_ARB_HEADER_EN
        drive(4'b0100, 4'b0, 1'b0, 32'h0011_0000);
        expect_slot("single hdr", 4'b0100, 1'b1, 1'b1, 4'b0, 1'b1, 8'hA2);
`endif
        drive(4'b0100, 4'b0, 1'b0, 32'h0011_0000);
        expect_slot("single d0", 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h11);
        drive(4'b0100, 4'b0100, 1'b0, 32'h0022_0000);
        expect_slot("single d1", 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h22);
        drive(4'b0, 4'b0, 1'b0, 32'h0);
        expect_slot("single end", 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 8'h00);

        // Requester 1 wins (scan starts at 3), then reset mid-burst
        drive(4'b0010, 4'b0, 1'b0, 32'h0000_5500);
        expect_slot("rst pre", 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 8'h00);
`ifdef USART_ARB_HEADER_EN
        drive(4'b0010, 4'b0, 1'b0, 32'h0000_5500);
        expect_slot("rst hdr", 4'b0010, 1'b1, 1'b1, 4'b0, 1'b1, 8'hA1);
`endif
        drive(4'b0010, 4'b0, 1'b0, 32'h0000_5500);
        expect_slot("rst d0", 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 8'h55);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b0;
        #1;
        expect_slot("rst mid", 4'b0, 1'b0, 1'b0, 4'b0, 1'b1, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Round robin: all valid, no last, bursts cut at MAX_BURST; order restarts at 0
        drive(4'hF, 4'b0, 1'b0, rr_data);
        expect_slot("rr start", 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 8'h00);
        for (int b = 0; b < 5; b++) begin
            g  = 2'(b % 4);
            oh = 4'b0001 << g;
`ifdef USART_ARB_HEADER_EN
            drive(4'hF, 4'b0, 1'b0, rr_data);
            expect_slot("rr hdr", oh, 1'b1, 1'b1, 4'b0, 1'b1, {6'b101000, g});
`endif
            for (int k = 0; k < 4; k++) begin
                drive(4'hF, 4'b0, 1'b0, rr_data);
                expect_slot("rr data", oh, 1'b1, 1'b1, oh, 1'b1, rr_byte[g]);
            end
            drive(4'hF, 4'b0, 1'b0, rr_data);
            expect_slot("rr idle", 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 8'h00);
        end

        // Backpressure inside requester 1's burst; byte count stays at 4
`ifdef USART_ARB_HEADER_EN
        drive(4'hF, 4'b0, 1'b0, rr_data);
        expect_slot("bp hdr", 4'b0010, 1'b1, 1'b1, 4'b0, 1'b1, 8'hA1);
`endif
        drive(4'hF, 4'b0, 1'b0, rr_data);
        expect_slot("bp d0", 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 8'h12);
        repeat (5) begin
            drive(4'hF, 4'b0, 1'b1, rr_data);
            expect_slot("bp full", 4'b0010, 1'b1, 1'b0, 4'b0, 1'b1, 8'h12);
        end
        repeat (3) begin
            drive(4'hF, 4'b0, 1'b0, rr_data);
            expect_slot("bp rest", 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 8'h12);
        end
        drive(4'hF, 4'b0, 1'b0, rr_data);
        expect_slot("bp idle", 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 8'h00);

        // Valid gap on requester 2: grant held, no writes, others never ready
`ifdef USART_ARB_HEADER_EN
        drive(4'hF, 4'b0, 1'b0, rr_data);
        expect_slot("gap hdr", 4'b0100, 1'b1, 1'b1, 4'b0, 1'b1, 8'hA2);
`endif
        drive(4'hF, 4'b0, 1'b0, rr_data);
        expect_slot("gap d0", 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h23);
        repeat (3) begin
            drive(4'b1011, 4'b0, 1'b0, rr_data);
            expect_slot("gap wait", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 8'h23);
        end
        drive(4'hF, 4'b0100, 1'b0, rr_data);
        expect_slot("gap last", 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 8'h23);
        drive(4'hF, 4'b0, 1'b0, rr_data);
        expect_slot("gap idle", 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 8'h00);
        drive(4'hF, 4'b0, 1'b0, rr_data);
`ifdef USART_ARB_HEADER_EN
        expect_slot("next hdr", 4'b1000, 1'b1, 1'b1, 4'b0, 1'b1, 8'hA3);
`else
        expect_slot("next d0", 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 8'h34);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
